// File: rtl/sys_bridge_n.sv
// M-stage memory bridge: decodes DM / interrupt-generator / N timer devices, steers store strobes,
// returns load data one cycle later. Optional sticky fault capture is built when SYS_BRIDGE_ERR_EN is defined.
module sys_bridge_n #(
   parameter int          N_DEV      = 2,
   parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
   parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
   parameter logic [31:0] DM_HI      = 32'h0000_2FFF,
   parameter logic [31:0] INT_LO     = 32'h0000_7F20,
   parameter logic [31:0] INT_HI     = 32'h0000_7F23
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [31:0]           cpu_addr,
   input  logic [3:0]            cpu_byteen,
   input  logic                  cpu_rd,
   input  logic [31:0]           dm_rdata,
   input  logic [32*N_DEV-1:0]   dev_rdata,
   output logic [3:0]            dm_byteen,
   output logic [3:0]            int_byteen,
   output logic [N_DEV-1:0]      dev_we,
   output logic [31:0]           rdata,
   output logic                  rdata_valid,
   input  logic                  err_clr,
   output logic                  err_valid,
   output logic [1:0]            err_code,
   output logic [31:0]           err_addr
);

   logic               dm_hit;
   logic               int_hit;
   logic               dev_hit;
   logic [N_DEV-1:0]   dev_oh;
   logic [31:0]        dev_data;
   logic [31:0]        dev_lo;
   logic               is_store;
   logic               is_load;
   logic               wr_off;
   logic [31:0]        ld_data;

   logic [31:0]        rdata_q, rdata_d;
   logic               rdata_valid_q, rdata_valid_d;

   assign is_store = |cpu_byteen;
   // A load that collides with a store is dropped; the store wins.
   assign is_load  = cpu_rd & ~is_store;
   assign dm_hit   = (cpu_addr <= DM_HI);
   assign int_hit  = ~dm_hit & (cpu_addr >= INT_LO) & (cpu_addr <= INT_HI);
   assign wr_off   = (cpu_addr[3:2] == 2'd0) | (cpu_addr[3:2] == 2'd1);

   always_comb begin
      dev_hit  = 1'b0;
      dev_oh   = '0;
      dev_data = '0;
      dev_lo   = '0;
      for (int k = 0; k < N_DEV; k++) begin
         dev_lo = DEV_BASE + DEV_STRIDE * 32'(k);
         if (!dev_hit && (cpu_addr >= dev_lo) && (cpu_addr <= dev_lo + 32'hB) &&
             (cpu_addr[3:2] != 2'd3)) begin
            dev_hit   = 1'b1;
            dev_oh[k] = 1'b1;
            dev_data  = dev_rdata[32*k +: 32];
         end
      end
      if (dm_hit || int_hit) begin
         dev_hit = 1'b0;
         dev_oh  = '0;
      end
   end

   assign dm_byteen  = (is_store && dm_hit)  ? cpu_byteen : 4'h0;
   assign int_byteen = (is_store && int_hit) ? cpu_byteen : 4'h0;
   assign dev_we     = (is_store && (cpu_byteen == 4'hF) && wr_off) ? dev_oh : '0;

   always_comb begin
      ld_data = '0;
      if (dm_hit)
         ld_data = dm_rdata;
      else if (dev_hit)
         ld_data = dev_data;
   end

   always_comb begin
      rdata_d       = rdata_q;
      rdata_valid_d = is_load;
      if (is_load)
         rdata_d = ld_data;
   end

   // Load response register: one-cycle latency, data held between loads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

`ifdef SYS_BRIDGE_ERR_EN
   logic        mapped;
   logic        fault;
   logic [1:0]  fault_code;
   logic        err_valid_q, err_valid_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [31:0] err_addr_q, err_addr_d;

   assign mapped = dm_hit | int_hit | dev_hit;

   always_comb begin
      fault      = 1'b0;
      fault_code = 2'b00;
      if (!mapped && (is_store || is_load)) begin
         fault      = 1'b1;
         fault_code = 2'b01;
      end else if (is_store && dev_hit && (cpu_byteen != 4'hF)) begin
         fault      = 1'b1;
         fault_code = 2'b10;
      end else if (is_store && dev_hit && !wr_off) begin
         fault      = 1'b1;
         fault_code = 2'b11;
      end
   end

   // First fault wins; a clear in the same cycle as a new fault re-arms and captures it.
   always_comb begin
      err_valid_d = err_valid_q;
      err_code_d  = err_code_q;
      err_addr_d  = err_addr_q;
      if (fault && (!err_valid_q || err_clr)) begin
         err_valid_d = 1'b1;
         err_code_d  = fault_code;
         err_addr_d  = cpu_addr;
      end else if (err_clr) begin
         err_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_valid_q <= 1'b0;
         err_code_q  <= 2'b00;
         err_addr_q  <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_addr  = err_addr_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_valid      = 1'b0;
   assign err_code       = 2'b00;
   assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed table-driven bench for sys_bridge_n (N_DEV=2, default map); fault expectations
// collapse to zero when SYS_BRIDGE_ERR_EN is not defined.
module tb_sys_bridge_n;

`ifdef SYS_BRIDGE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [31:0] cpu_addr;
   logic [3:0]  cpu_byteen;
   logic        cpu_rd;
   logic [31:0] dm_rdata;
   logic [63:0] dev_rdata;
   logic [3:0]  dm_byteen;
   logic [3:0]  int_byteen;
   logic [1:0]  dev_we;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        err_clr;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_fail   = 0;

   sys_bridge_n #(.N_DEV(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_byteen (cpu_byteen),
      .cpu_rd     (cpu_rd),
      .dm_rdata   (dm_rdata),
      .dev_rdata  (dev_rdata),
      .dm_byteen  (dm_byteen),
      .int_byteen (int_byteen),
      .dev_we     (dev_we),
      .rdata      (rdata),
      .rdata_valid(rdata_valid),
      .err_clr    (err_clr),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_addr   (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        rd;
      logic        clr;
      logic [31:0] dmd;
      logic [63:0] devd;
      logic [3:0]  e_dm;
      logic [3:0]  e_int;
      logic [1:0]  e_we;
      logic [31:0] e_rdata;
      logic        e_rv;
      logic        e_ev;
      logic [1:0]  e_code;
      logic [31:0] e_eaddr;
   } vec_t;

   vec_t v[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic rd,
                        input logic clr, input logic [31:0] dmd, input logic [63:0] devd);
      cpu_addr   = a;
      cpu_byteen = be;
      cpu_rd     = rd;
      err_clr    = clr;
      dm_rdata   = dmd;
      dev_rdata  = devd;
   endtask

   task automatic chk_err(input string tag, input logic ev, input logic [1:0] code,
                          input logic [31:0] ea);
      chk({tag, ".err_valid"}, 32'(err_valid), ERR_EN ? 32'(ev) : 32'h0);
      chk({tag, ".err_code"},  32'(err_code),  ERR_EN ? 32'(code) : 32'h0);
      chk({tag, ".err_addr"},  err_addr,       ERR_EN ? ea : 32'h0);
   endtask

   initial begin
      //            addr          be    rd    clr   dmd            devd                              dm    int   we     rdata          rv    ev    code   eaddr
      v.push_back('{32'h7F10, 4'hF, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b10, 32'h0,         1'b0, 1'b0, 2'd0, 32'h0});
      v.push_back('{32'h7F04, 4'h3, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 2'd2, 32'h7F04});
      v.push_back('{32'h1000, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF,  64'h0,                            4'h0, 4'h0, 2'b00, 32'hDEADBEEF,  1'b1, 1'b1, 2'd2, 32'h7F04});
      v.push_back('{32'h7F14, 4'h0, 1'b1, 1'b0, 32'h0,         {32'h5, 32'hAAAA_0000},           4'h0, 4'h0, 2'b00, 32'h5,         1'b1, 1'b1, 2'd2, 32'h7F04});
      v.push_back('{32'h0,    4'h0, 1'b0, 1'b0, 32'h1,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h5,         1'b0, 1'b1, 2'd2, 32'h7F04});
      v.push_back('{32'h7F08, 4'hF, 1'b0, 1'b1, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h5,         1'b0, 1'b1, 2'd3, 32'h7F08});
      v.push_back('{32'h4000, 4'h0, 1'b1, 1'b0, 32'h2222,      64'h3333,                         4'h0, 4'h0, 2'b00, 32'h0,         1'b1, 1'b1, 2'd3, 32'h7F08});
      v.push_back('{32'h3000, 4'h0, 1'b1, 1'b1, 32'h1111_1111, 64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b1, 1'b1, 2'd1, 32'h3000});
      v.push_back('{32'h0,    4'h0, 1'b0, 1'b1, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b0, 2'd1, 32'h3000});
      v.push_back('{32'h7F21, 4'h1, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h1, 2'b00, 32'h0,         1'b0, 1'b0, 2'd1, 32'h3000});
      v.push_back('{32'h0010, 4'hC, 1'b0, 1'b0, 32'h0,         64'h0,                            4'hC, 4'h0, 2'b00, 32'h0,         1'b0, 1'b0, 2'd1, 32'h3000});
      v.push_back('{32'h7F00, 4'hF, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b01, 32'h0,         1'b0, 1'b0, 2'd1, 32'h3000});
      v.push_back('{32'h7F0C, 4'hF, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F18, 4'hF, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h2FFF, 4'h0, 1'b1, 1'b0, 32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF,          4'h0, 4'h0, 2'b00, 32'h1234_5678, 1'b1, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F14, 4'hF, 1'b1, 1'b0, 32'h99,        64'h77,                           4'h0, 4'h0, 2'b10, 32'h1234_5678, 1'b0, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F20, 4'h0, 1'b1, 1'b0, 32'h4444,      64'h5555_6666,                    4'h0, 4'h0, 2'b00, 32'h0,         1'b1, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F08, 4'h0, 1'b1, 1'b0, 32'h0,         {32'h1234, 32'hCAFE_0001},        4'h0, 4'h0, 2'b00, 32'hCAFE_0001, 1'b1, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F0C, 4'h0, 1'b1, 1'b0, 32'h8888,      64'h9999,                         4'h0, 4'h0, 2'b00, 32'h0,         1'b1, 1'b1, 2'd1, 32'h7F0C});
      v.push_back('{32'h7F18, 4'h3, 1'b0, 1'b1, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 2'd2, 32'h7F18});
      v.push_back('{32'h0,    4'h0, 1'b0, 1'b0, 32'h0,         64'h0,                            4'h0, 4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 2'd2, 32'h7F18});

      reset_n = 1'b0;
      drive(32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rdata", rdata, 32'h0);
      chk("reset.rdata_valid", 32'(rdata_valid), 32'h0);
      chk_err("reset", 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < v.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(v[i].addr, v[i].be, v[i].rd, v[i].clr, v[i].dmd, v[i].devd);
         #3;
         chk({tag, ".dm_byteen"},  32'(dm_byteen),  32'(v[i].e_dm));
         chk({tag, ".int_byteen"}, 32'(int_byteen), 32'(v[i].e_int));
         chk({tag, ".dev_we"},     32'(dev_we),     32'(v[i].e_we));
         @(posedge clk);
         #1;
         chk({tag, ".rdata"},       rdata,             v[i].e_rdata);
         chk({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(v[i].e_rv));
         chk_err(tag, v[i].e_ev, v[i].e_code, v[i].e_eaddr);
      end

      // Load completes, then reset during the valid cycle and during a pending load.
      drive(32'h1000, 4'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 64'h0);
      @(posedge clk);
      #1;
      chk("preload.rdata", rdata, 32'h0BAD_F00D);
      chk("preload.rdata_valid", 32'(rdata_valid), 32'h1);
      drive(32'h1004, 4'h0, 1'b1, 1'b0, 32'h7777_7777, 64'h0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst.rdata", rdata, 32'h0);
      chk("midrst.rdata_valid", 32'(rdata_valid), 32'h0);
      chk_err("midrst", 1'b0, 2'd0, 32'h0);
      drive(32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst.rdata_valid", 32'(rdata_valid), 32'h0);
      chk("postrst.rdata", rdata, 32'h0);

      // Two back-to-back loads produce two consecutive valid cycles.
      drive(32'h0004, 4'h0, 1'b1, 1'b0, 32'hA5A5_0001, 64'h0);
      @(posedge clk);
      #1;
      chk("b2b0.rdata", rdata, 32'hA5A5_0001);
      chk("b2b0.rdata_valid", 32'(rdata_valid), 32'h1);
      drive(32'h7F00, 4'h0, 1'b1, 1'b0, 32'h0, {32'h0, 32'h0000_0ABC});
      @(posedge clk);
      #1;
      chk("b2b1.rdata", rdata, 32'h0000_0ABC);
      chk("b2b1.rdata_valid", 32'(rdata_valid), 32'h1);
      drive(32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 64'h0);
      @(posedge clk);
      #1;
      chk("b2b2.rdata_valid", 32'(rdata_valid), 32'h0);
      chk("b2b2.rdata", rdata, 32'h0000_0ABC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
